// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
//
// Pulls the PS/2 clock low for INHIBIT_CYCLES, issues a request-to-send
// (start bit), and then shifts out 8 data bits LSB first, odd parity and stop
// on the device-generated clock. It then samples the device ack bit.
//
// Ports
//   clk, rst_n                  system clock, async active-low reset
//   tx_data[7:0], tx_valid      command byte + request (taken when tx_ready)
//   tx_ready                    high only when idle
//   ps2_clk_in, ps2_data_in     raw (asynchronous) pin levels
//   ps2_clk_low, ps2_data_low   open-drain enables, 1 = pull pin low
//   done, ack_err, timeout      single-cycle completion pulses
//   busy                        high whenever not idle
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  output logic       done,
  output logic       ack_err,
  output logic       timeout,
  output logic       busy
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, SEND, ACK, WAIT_IDLE} state_t;

  state_t      state_q;
  logic [IW-1:0] cnt_q;
  logic [TW-1:0] tout_q;
  logic [8:0]  shreg_q;      // {parity, data}
  logic [3:0]  idx_q;        // index of the bit currently on the data line
  logic        clk_low_q, data_low_q;
  logic        done_q, ack_err_q, timeout_q;

  // Pin synchronizers; idle bus level is high, so reset to 1.
  logic clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q, fe_q;
  logic fe_d;
  assign fe_d = clk_prev_q & ~clk_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      fe_q       <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data_in;
      dat_s2_q   <= dat_s1_q;
      fe_q       <= fe_d;
    end
  end

  logic active, lines_idle, tout_hit;
  assign active     = (state_q == REQUEST) || (state_q == SEND) ||
                      (state_q == ACK) || (state_q == WAIT_IDLE);
  assign lines_idle = clk_s2_q & dat_s2_q;
  // A bus that comes back idle in WAIT_IDLE wins over a simultaneous expiry.
  assign tout_hit   = active && !fe_q && (tout_q == TW'(TIMEOUT_CYCLES - 1)) &&
                      !((state_q == WAIT_IDLE) && lines_idle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tout_q     <= '0;
      shreg_q    <= '0;
      idx_q      <= '0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;

      if (active) tout_q <= fe_q ? '0 : tout_q + 1'b1;

      case (state_q)
        IDLE: begin
          clk_low_q  <= 1'b0;
          data_low_q <= 1'b0;
          if (tx_valid) begin
            shreg_q    <= {~^tx_data, tx_data};
            cnt_q      <= '0;
            clk_low_q  <= 1'b1;
            // Start bit must already be asserted if the inhibit is one cycle.
            data_low_q <= (INHIBIT_CYCLES == 1);
            state_q    <= INHIBIT;
          end
        end
        INHIBIT: begin
          cnt_q <= cnt_q + 1'b1;
          // Start bit goes out one cycle before the clock is released.
          if (cnt_q == IW'(INHIBIT_CYCLES - 2)) data_low_q <= 1'b1;
          if (cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
            clk_low_q <= 1'b0;
            tout_q    <= '0;
            idx_q     <= '0;
            state_q   <= REQUEST;
          end
        end
        REQUEST: begin
          if (fe_q) begin
            data_low_q <= ~shreg_q[0];
            idx_q      <= '0;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (fe_q) begin
            if (idx_q == 4'd8) begin
              data_low_q <= 1'b0;       // stop bit = released line
              state_q    <= ACK;
            end else begin
              idx_q      <= idx_q + 4'd1;
              data_low_q <= ~shreg_q[idx_q + 4'd1];
            end
          end
        end
        ACK: begin
          if (fe_q) begin
            if (!dat_s2_q) done_q    <= 1'b1;
            else           ack_err_q <= 1'b1;
            state_q <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          clk_low_q  <= 1'b0;
          data_low_q <= 1'b0;
          if (lines_idle) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Watchdog overrides any state move above.
      if (tout_hit) begin
        timeout_q  <= 1'b1;
        clk_low_q  <= 1'b0;
        data_low_q <= 1'b0;
        state_q    <= IDLE;
      end
    end
  end

  assign tx_ready     = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign ps2_clk_low  = clk_low_q;
  assign ps2_data_low = data_low_q;
  assign done         = done_q;
  assign ack_err      = ack_err_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int INH = 8;
  localparam int TO  = 200;
  localparam int HALF_PS2 = 20;    // device clock: 40 clk period

  // result codes on the scoreboard
  localparam int R_NONE = 0, R_DONE = 1, R_NACK = 2, R_TO = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_low, ps2_data_low, done, ack_err, timeout, busy;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;

  // open-drain bus: either side may pull low
  assign ps2_clk_in  = ~(ps2_clk_low | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_low | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_low(ps2_clk_low), .ps2_data_low(ps2_data_low), .done(done),
    .ack_err(ack_err), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard
  int          exp_code_q[$];
  logic [10:0] exp_frame_q[$];
  int          obs_q[$];

  // monitors
  int cyc = 0, run = 0, last_run = 0, n_inh = 0, n_multi = 0, to_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done)    obs_q.push_back(R_DONE);
    if (ack_err) obs_q.push_back(R_NACK);
    if (timeout) begin obs_q.push_back(R_TO); to_cyc <= cyc; end
    if ((int'(done) + int'(ack_err) + int'(timeout)) > 1) n_multi <= n_multi + 1;
    if (ps2_clk_low) run <= run + 1;
    else if (run != 0) begin last_run <= run; n_inh <= n_inh + 1; run <= 0; end
  end

  function automatic logic odd_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0);
  endfunction

  task automatic send(input logic [7:0] d, input int code);
    int w = 0;
    while (!tx_ready && w < 500) begin @(negedge clk); w++; end
    chk("send_ready", tx_ready, 1);
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~d;               // must not leak into the frame
    exp_code_q.push_back(code);
    exp_frame_q.push_back({1'b1, odd_par(d), d, 1'b0});
  endtask

  int last_fe_cyc = 0;

  // Device: waits for the request, clocks n_fe falling edges, samples data at
  // every rising edge (start bit sampled at request detection), acks on 11th.
  task automatic dev_run(input int n_fe, input bit ack, output logic [10:0] frame);
    int w = 0;
    frame = '0;
    while (!(ps2_clk_in && !ps2_data_in) && w < 500) begin @(negedge clk); w++; end
    chk("dev_req_seen", (w < 500), 1);
    if (w >= 500) return;
    repeat (10) @(negedge clk);
    frame[0] = ps2_data_in;
    for (int k = 1; k <= n_fe; k++) begin
      if (k == 11 && ack) begin
        dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      last_fe_cyc = cyc;
      repeat (HALF_PS2) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) frame[k] = ps2_data_in;
      if (k == 11) begin
        repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
      end
      repeat (HALF_PS2) @(negedge clk);
    end
  endtask

  task automatic get_result(input string tag, input logic [10:0] dev_frame, input bit full);
    int w = 0;
    int code_e;
    logic [10:0] fr_e;
    code_e = exp_code_q.pop_front();
    fr_e   = exp_frame_q.pop_front();
    if (code_e == R_NONE) begin
      chk({tag, "_no_pulse"}, obs_q.size(), 0);
      return;
    end
    while (obs_q.size() == 0 && w < 400) begin @(negedge clk); w++; end
    if (obs_q.size() == 0) chk({tag, "_result_wait"}, R_NONE, code_e);
    else                   chk({tag, "_result"}, obs_q.pop_front(), code_e);
    if (full) chk({tag, "_frame"}, dev_frame, fr_e);
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!tx_ready && w < 300) begin @(negedge clk); w++; end
    chk({tag, "_ready"}, tx_ready, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  logic [10:0] fr;
  int inh_before, d;

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_clk_low", ps2_clk_low, 0);
    chk("rst_data_low", ps2_data_low, 0);
    chk("rst_pulses", {done, ack_err, timeout}, 3'b000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED acked: frame 0,1,0,1,1,0,1,1,1, parity 1, stop 1
    send(8'hED, R_DONE);
    dev_run(11, 1'b1, fr);
    chk("ed_frame_const", fr, 11'b11_1110_1101_0);
    get_result("ed", fr, 1'b1);
    chk("ed_inhibit_len", last_run, INH);
    wait_ready("ed");

    // 0x07 with no ack: parity 0, ack_err only
    send(8'h07, R_NACK);
    dev_run(11, 1'b0, fr);
    chk("07_parity", fr[9], 0);
    get_result("07", fr, 1'b1);
    chk("07_inhibit_len", last_run, INH);
    wait_ready("07");

    // device stalls after 4 falling edges -> timeout
    send(8'hA3, R_TO);
    dev_run(4, 1'b0, fr);
    get_result("to", fr, 1'b0);
    // pin edge -> 2-flop sync -> registered fe adds a few cycles to TO
    d = to_cyc - last_fe_cyc;
    chk("to_delay_ok", (d >= TO && d <= TO + 6), 1);
    @(negedge clk);
    chk("to_clk_low", ps2_clk_low, 0);
    chk("to_data_low", ps2_data_low, 0);
    chk("to_idle", tx_ready, 1);

    // 0xFF while a 0x55 request is attempted twice during the transfer
    inh_before = n_inh;
    send(8'hFF, R_DONE);
    fork
      dev_run(11, 1'b1, fr);
      begin
        repeat (3) @(negedge clk);
        tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0;
        repeat (150) @(negedge clk);
        tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0;
      end
    join
    chk("ff_frame_const", fr, 11'b11_1111_1111_0);
    get_result("ff", fr, 1'b1);
    wait_ready("ff");
    repeat (50) @(negedge clk);
    chk("ff_one_inhibit", n_inh, inh_before + 1);
    chk("ff_no_extra", obs_q.size(), 0);

    // reset while bit 3 is on the line: async release, no pulse
    send(8'h3C, R_NONE);
    dev_run(4, 1'b0, fr);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_clk_low", ps2_clk_low, 0);
    chk("rst_mid_data_low", ps2_data_low, 0);
    chk("rst_mid_ready", tx_ready, 1);
    chk("rst_mid_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    get_result("rst", fr, 1'b0);

    send(8'h00, R_DONE);
    dev_run(11, 1'b1, fr);
    chk("00_parity", fr[9], 1);
    get_result("00", fr, 1'b1);
    chk("00_inhibit_len", last_run, INH);
    wait_ready("00");

    chk("pulse_exclusive", n_multi, 0);
    chk("sb_empty", obs_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter: INHIBIT_CYCLES, default 5000, clk cycles ps2 clock held low before request (100 us at 50 MHz).
REQ-002 Parameter: TIMEOUT_CYCLES, default 1000000, max clk cycles between device falling edges before abort.
REQ-003 Port: clk  input  1  system clock, all state on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: tx_data  input  8  command byte to send to the keyboard.
REQ-006 Port: tx_valid  input  1  request; accepted when tx_valid and tx_ready are both high.
REQ-007 Port: tx_ready  output  1  high only in IDLE.
REQ-008 Port: ps2_clk_in / ps2_data_in  input  1 each  raw pin levels (asynchronous).
REQ-009 Port: ps2_clk_low / ps2_data_low  output  1 each  open-drain enables, 1 = drive pin low, 0 = release.
REQ-010 Port: done / ack_err / timeout  output  1 each  single-cycle completion pulses.
REQ-011 Port: busy  output  1  high in every state except IDLE.

Function
REQ-012 ps2_clk_in and ps2_data_in SHALL each pass a 2-flop synchronizer; a falling edge (fe) SHALL be prev_sync=1 and sync=0, registered.
REQ-013 On accept, tx_data SHALL be latched, with odd parity (parity = ~^tx_data); later tx_data changes are ignored.
REQ-014 States: IDLE, INHIBIT, REQUEST, SEND, ACK, WAIT_IDLE.
REQ-015 IDLE: both drive outputs 0; accept -> INHIBIT, cycle counter cleared.
REQ-016 INHIBIT: ps2_clk_low=1 for exactly INHIBIT_CYCLES cycles; ps2_data_low=1 during the last cycle; then -> REQUEST.
REQ-017 REQUEST: ps2_clk_low=0, ps2_data_low=1 (start bit 0); bit index=0; first fe -> SEND, driving data bit 0.
REQ-018 SEND: on each fe, the next bit SHALL be driven in the cycle after fe detection, order data[0..7], parity, then stop (ps2_data_low=0); ps2_data_low = ~bit.
REQ-019 The fe that presents the stop bit SHALL move to ACK; the next fe SHALL sample ps2_data_in sync: 0 -> done pulse, 1 -> ack_err pulse; both -> WAIT_IDLE.
REQ-020 WAIT_IDLE: both lines released; -> IDLE once both synchronized lines are 1.
REQ-021 Timeout counter SHALL clear on every fe and on entry to REQUEST; in REQUEST/SEND/ACK/WAIT_IDLE, reaching TIMEOUT_CYCLES -> timeout pulse, both lines released next cycle, -> IDLE.
REQ-022 tx_valid while busy SHALL be ignored, with no queuing.
REQ-023 done, ack_err, timeout SHALL be mutually exclusive; exactly one pulses per accepted transfer.
REQ-024 ps2_clk_low SHALL never be 1 outside INHIBIT.
REQ-025 Rising edges on ps2_clk SHALL not alter state.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) force IDLE, release both lines, and clear counters, latched data and pulses; tx_ready=1, busy=0.
REQ-027 Reset mid-transfer SHALL abort with no completion pulse; the first request after reset restarts from INHIBIT.

Verification (bench: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=200, device model clocks ps2 at 40-clk period)
REQ-028 tx_data=0xED, device acks low -> ps2_clk_low high for 8 cycles; data bits seen at device rising edges 0,1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; tx_ready returns 1.
REQ-029 tx_data=0x07, device leaves data high at 11th fe -> parity bit 0 observed; ack_err pulses once, done stays 0.
REQ-030 Device stops clocking after 4 fe -> timeout pulses 200 cycles after the last fe; both drive outputs 0 the next cycle; state IDLE.
REQ-031 Second tx_valid with 0x55 while busy sending 0xFF -> ignored; only 0xFF bits (parity 1) transmitted; one done pulse.
REQ-032 rst_n low during SEND bit 3 -> ps2_clk_low=ps2_data_low=0 with no clock edge; no pulses; a new 0x00 request (parity 1) completes with done.
